// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave SRAM-like bus arbiter with data-priority
// grant, grant lock until acceptance, and an in-order owner FIFO for response routing.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  output logic              s_req,
  output logic              s_wr,
  output logic [1:0]        s_size,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_addr_ok,
  input  logic              s_data_ok,
  input  logic [DATA_W-1:0] s_rdata,

  output logic              spurious_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int OCC_W = $clog2(OUTSTANDING + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic                   run_q;
  logic                   lock_q;
  logic                   lock_owner_q;
  logic                   spurious_q;
  logic [OUTSTANDING-1:0] owner_mem;
  logic [PTR_W-1:0]       wptr_q;
  logic [PTR_W-1:0]       rptr_q;
  logic [OCC_W-1:0]       occ_q;

  logic gnt_valid;
  logic gnt_owner;
  logic gnt_req;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A locked owner stays granted even if the other master now has priority.
  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_owner = OWN_INST;
    if (lock_q) begin
      gnt_valid = 1'b1;
      gnt_owner = lock_owner_q;
    end else if (data_req) begin
      gnt_valid = 1'b1;
      gnt_owner = OWN_DATA;
    end else if (inst_req) begin
      gnt_valid = 1'b1;
      gnt_owner = OWN_INST;
    end
  end

  assign gnt_req = (gnt_owner == OWN_DATA) ? data_req : inst_req;
  assign full    = (occ_q == OCC_FULL);
  assign empty   = (occ_q == '0);

  // run_q keeps all handshake outputs low until the first edge after reset release.
  assign s_req = run_q & gnt_valid & gnt_req & ~full;
  assign push  = s_req & s_addr_ok;
  assign pop   = run_q & s_data_ok & ~empty;
  assign head  = owner_mem[rptr_q];

  always_comb begin
    s_wr    = 1'b0;
    s_size  = '0;
    s_addr  = '0;
    s_wdata = '0;
    if (gnt_valid) begin
      if (gnt_owner == OWN_DATA) begin
        s_wr    = data_wr;
        s_size  = data_size;
        s_addr  = data_addr;
        s_wdata = data_wdata;
      end else begin
        s_wr    = inst_wr;
        s_size  = inst_size;
        s_addr  = inst_addr;
        s_wdata = inst_wdata;
      end
    end
  end

  assign inst_addr_ok = push & (gnt_owner == OWN_INST);
  assign data_addr_ok = push & (gnt_owner == OWN_DATA);
  assign inst_data_ok = pop & (head == OWN_INST);
  assign data_data_ok = pop & (head == OWN_DATA);
  assign inst_rdata   = s_rdata;
  assign data_rdata   = s_rdata;
  assign spurious_err = spurious_q;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run_q        <= 1'b0;
      lock_q       <= 1'b0;
      lock_owner_q <= OWN_INST;
      spurious_q   <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      occ_q        <= '0;
    end else begin
      run_q <= 1'b1;

      if (push) begin
        lock_q <= 1'b0;
      end else if (s_req) begin
        lock_q       <= 1'b1;
        lock_owner_q <= gnt_owner;
      end

      if (run_q && s_data_ok && empty) begin
        spurious_q <= 1'b1;
      end

      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);

      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // NOTE: owner storage is not reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) owner_mem[wptr_q] <= gnt_owner;
  end

endmodule
